// File: rtl/plab5_mcore_net_msg_to_mem_req_pkg.sv
// Shared message layout for the bank-side network-to-memory-request adapter.
// Memory request: {type, opaque, addr, len, data}
// Network control flit: {dest, src, net_opaque, {req_domain, type, opaque, addr, len}}
package plab5_mcore_net_msg_to_mem_req_pkg;

   typedef enum logic [2:0] {
      memreq_type_read    = 3'd0,
      memreq_type_write   = 3'd1,
      memreq_type_init    = 3'd2,
      memreq_type_amo_add = 3'd3,
      memreq_type_amo_and = 3'd4,
      memreq_type_amo_or  = 3'd5
   } memreq_type_e;

   localparam int c_memreq_type_nbits = 3;

   // Byte-length field: enough bits to count the bytes of one data word.
   function automatic int memreq_len_nbits(input int md);
      return $clog2(md / 8);
   endfunction

   function automatic int memreq_msg_nbits(input int mo, input int ma, input int md);
      return c_memreq_type_nbits + mo + ma + memreq_len_nbits(md) + md;
   endfunction

   // Control payload is the request without its data word, plus the domain bit on top.
   function automatic int ctrl_payload_nbits(input int mo, input int ma, input int md);
      return memreq_msg_nbits(mo, ma, md) - md + 1;
   endfunction

   function automatic int net_msg_nbits(input int pn, input int no, input int ns);
      return pn + no + 2 * ns;
   endfunction

   function automatic int req_domain_bit(input int mo, input int ma, input int md);
      return ctrl_payload_nbits(mo, ma, md) - 1;
   endfunction

   // Domain bit position for the default 8/32/32 request geometry.
   localparam int PLAB5_MCORE_REQ_DOMAIN_BIT = req_domain_bit(8, 32, 32);

endpackage

// File: rtl/plab5_mcore_net_msg_to_mem_req_if.sv
// Handshake bundle between the request network, the adapter and the memory bank.
// Both channels use val/rdy: a beat transfers on a rising clk edge iff val && rdy;
// once val is raised the message is held stable until the transfer, and val never
// depends combinationally on rdy.
interface plab5_mcore_net_msg_to_mem_req_if #(
   parameter int p_ctrl_nbits = 56,
   parameter int p_data_nbits = 32,
   parameter int p_req_nbits  = 77
);
   logic                    net_val;
   logic                    net_rdy;
   logic [p_ctrl_nbits-1:0] net_msg_control;
   logic [p_data_nbits-1:0] net_msg_data;
   logic                    memreq_val;
   logic                    memreq_rdy;
   logic [p_req_nbits-1:0]  memreq_msg;

   // Environment side: injects network flits, consumes memory requests.
   modport master (
      output net_val, net_msg_control, net_msg_data, memreq_rdy,
      input  net_rdy, memreq_val, memreq_msg
   );

   // Adapter side.
   modport slave (
      input  net_val, net_msg_control, net_msg_data, memreq_rdy,
      output net_rdy, memreq_val, memreq_msg
   );
endinterface

// File: rtl/plab5_mcore_net_msg_to_mem_req_unpack.sv
// Splits the memory-request control payload {type, opaque, addr, len} into fields.
// Mirror of the core-side control packer.
module plab5_mcore_net_msg_to_mem_req_unpack
   import plab5_mcore_net_msg_to_mem_req_pkg::*;
#(
   parameter  int p_opaque_nbits = 8,
   parameter  int p_addr_nbits   = 32,
   parameter  int p_data_nbits   = 32,
   localparam int c_len_nbits    = memreq_len_nbits(p_data_nbits),
   localparam int c_nbits        = c_memreq_type_nbits + p_opaque_nbits + p_addr_nbits + c_len_nbits
)
(
   input  logic [c_nbits-1:0]        ctrl,
   output memreq_type_e              req_type,
   output logic [p_opaque_nbits-1:0] opaque,
   output logic [p_addr_nbits-1:0]   addr,
   output logic [c_len_nbits-1:0]    len
);
   assign len      = ctrl[c_len_nbits-1:0];
   assign addr     = ctrl[c_len_nbits +: p_addr_nbits];
   assign opaque   = ctrl[c_len_nbits + p_addr_nbits +: p_opaque_nbits];
   assign req_type = memreq_type_e'(ctrl[c_len_nbits + p_addr_nbits + p_opaque_nbits +: c_memreq_type_nbits]);
endmodule

// File: rtl/plab5_mcore_net_msg_to_mem_req.sv
// Bank-side receiver: filters network request flits by destination and security
// domain, buffers accepted requests in a 2-entry FIFO and presents them to the bank
// as full memory requests. Optional violation counter enabled by defining
// PLAB5_MCORE_NET_ADAPT_VIOL_CNT_EN.
module plab5_mcore_net_msg_to_mem_req
   import plab5_mcore_net_msg_to_mem_req_pkg::*;
#(
   parameter  int p_bank_id           = 0,
   parameter  int p_bank_domain       = 0,
   parameter  int p_mem_opaque_nbits  = 8,
   parameter  int p_mem_addr_nbits    = 32,
   parameter  int p_mem_data_nbits    = 32,
   parameter  int p_net_opaque_nbits  = 4,
   parameter  int p_net_srcdest_nbits = 3,
   localparam int c_req_nbits     = memreq_msg_nbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits),
   localparam int c_payload_nbits = ctrl_payload_nbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits),
   localparam int c_ctrl_nbits    = net_msg_nbits(c_payload_nbits, p_net_opaque_nbits, p_net_srcdest_nbits)
)
(
   input  logic       clk,
   input  logic       reset,
   plab5_mcore_net_msg_to_mem_req_if.slave bus,
   output logic       drop_pulse,
   output logic [7:0] viol_count
);
   localparam int c_len_nbits = memreq_len_nbits(p_mem_data_nbits);
   localparam int c_dom_bit   = req_domain_bit(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits);
   localparam logic [p_net_srcdest_nbits-1:0] c_bank_id = p_bank_id[p_net_srcdest_nbits-1:0];

   logic [p_net_srcdest_nbits-1:0] dest;
   logic                           req_domain;
   logic [c_payload_nbits-2:0]     req_ctrl;
   logic                           unused_net_hdr;

   assign dest       = bus.net_msg_control[c_ctrl_nbits-1 -: p_net_srcdest_nbits];
   assign req_domain = bus.net_msg_control[c_dom_bit];
   assign req_ctrl   = bus.net_msg_control[c_payload_nbits-2:0];
   // Source id and network opaque are only meaningful to the response path.
   assign unused_net_hdr = ^bus.net_msg_control[c_ctrl_nbits-p_net_srcdest_nbits-1 : c_payload_nbits];

   memreq_type_e                  u_type;
   logic [p_mem_opaque_nbits-1:0] u_opaque;
   logic [p_mem_addr_nbits-1:0]   u_addr;
   logic [c_len_nbits-1:0]        u_len;
   logic [c_req_nbits-1:0]        enq_msg;

   plab5_mcore_net_msg_to_mem_req_unpack #(
      .p_opaque_nbits (p_mem_opaque_nbits),
      .p_addr_nbits   (p_mem_addr_nbits),
      .p_data_nbits   (p_mem_data_nbits)
   ) u_unpack (
      .ctrl     (req_ctrl),
      .req_type (u_type),
      .opaque   (u_opaque),
      .addr     (u_addr),
      .len      (u_len)
   );

   // Memory opaque keeps the core id in its high bits for response routing.
   assign enq_msg = {u_type, u_opaque, u_addr, u_len, bus.net_msg_data};

   logic [c_req_nbits-1:0] q_entry [2];
   logic                   wr_ptr;
   logic                   rd_ptr;
   logic [1:0]             count;
   logic                   full;
   logic                   empty;
   logic                   enq_fire;
   logic                   pass;
   logic                   accept;
   logic                   drop;
   logic                   deq;

   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

   // net_rdy comes from the occupancy register only, so a full queue stalls the
   // network even while the bank is draining it this cycle.
   assign bus.net_rdy    = !full;
   assign bus.memreq_val = !empty;
   assign bus.memreq_msg = q_entry[rd_ptr];

   assign enq_fire = bus.net_val && !full;
   assign pass     = (dest == c_bank_id) && !((p_bank_domain != 0) && !req_domain);
   assign accept   = enq_fire && pass;
   assign drop     = enq_fire && !pass;
   assign deq      = !empty && bus.memreq_rdy;

   // Queue pointers and occupancy; reset discards any buffered requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (accept) wr_ptr <= ~wr_ptr;
         if (deq)    rd_ptr <= ~rd_ptr;
         case ({accept, deq})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; validity is tracked by count so no reset is needed.
   always_ff @(posedge clk) begin
      if (accept) q_entry[wr_ptr] <= enq_msg;
   end

   // One-cycle pulse the cycle after a consumed flit is discarded.
   always_ff @(posedge clk) begin
      if (reset) drop_pulse <= 1'b0;
      else       drop_pulse <= drop;
   end

`ifdef PLAB5_MCORE_NET_ADAPT_VIOL_CNT_EN
   logic [7:0] viol_q;

   // Saturating count of discarded flits, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)                      viol_q <= 8'h00;
      else if (drop && viol_q != 8'hFF) viol_q <= viol_q + 8'h01;
   end

   assign viol_count = viol_q;
`else
   assign viol_count = 8'h00;
`endif

endmodule

// File: tb/tb_plab5_mcore_net_msg_to_mem_req.sv
// Bench for the network-to-memory-request adapter: a public bank (id 0) and a
// secure bank (id 2) side by side, table-driven vectors plus back-pressure,
// streaming and reset/saturation sequences.
module tb_plab5_mcore_net_msg_to_mem_req;
   import plab5_mcore_net_msg_to_mem_req_pkg::*;

   localparam int REQ_W  = memreq_msg_nbits(8, 32, 32);
   localparam int CTRL_W = net_msg_nbits(ctrl_payload_nbits(8, 32, 32), 4, 3);
`ifdef PLAB5_MCORE_NET_ADAPT_VIOL_CNT_EN
   localparam bit VIOL_EN = 1'b1;
`else
   localparam bit VIOL_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   logic drop0, drop1;
   logic [7:0] viol0, viol1;

   plab5_mcore_net_msg_to_mem_req_if #(.p_ctrl_nbits(CTRL_W), .p_data_nbits(32), .p_req_nbits(REQ_W)) bus0();
   plab5_mcore_net_msg_to_mem_req_if #(.p_ctrl_nbits(CTRL_W), .p_data_nbits(32), .p_req_nbits(REQ_W)) bus1();

   plab5_mcore_net_msg_to_mem_req #(.p_bank_id(0), .p_bank_domain(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .drop_pulse(drop0), .viol_count(viol0)
   );
   plab5_mcore_net_msg_to_mem_req #(.p_bank_id(2), .p_bank_domain(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .drop_pulse(drop1), .viol_count(viol1)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard state ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [REQ_W-1:0] exp_q0[$];
   logic [REQ_W-1:0] exp_q1[$];
   int drops0 = 0;
   int drops1 = 0;

   typedef struct {
      bit          sel;
      logic [2:0]  dest;
      logic        dom;
      logic [2:0]  t;
      logic [7:0]  op;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
      bit          deliver;
   } vec_t;
   vec_t tbl[9];

   task automatic check1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic checkw(input string name, input logic [REQ_W-1:0] act, input logic [REQ_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_viol(input int drops);
      if (!VIOL_EN)    return 8'h00;
      if (drops > 255) return 8'hFF;
      return drops[7:0];
   endfunction

   function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [2:0] dest, input logic dom, input logic [2:0] t,
                                                 input logic [7:0] op, input logic [31:0] addr, input logic [1:0] len);
      logic [CTRL_W-1:0] c;
      c = {dest, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0, t, op, addr, len};
      c[PLAB5_MCORE_REQ_DOMAIN_BIT] = dom;
      return c;
   endfunction

   function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                                               input logic [1:0] len, input logic [31:0] data);
      return {t, op, addr, len, data};
   endfunction

   // ---------------- driver / monitor ----------------
   // Advance one cycle; memory-side outputs are compared at the falling edge.
   task automatic tick();
      logic [REQ_W-1:0] e;
      @(negedge clk);
      if (!reset) begin
         if (bus0.memreq_val && bus0.memreq_rdy) begin
            if (exp_q0.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_req0: got %h, required no request", bus0.memreq_msg);
            end else begin
               e = exp_q0.pop_front();
               checkw("memreq0", bus0.memreq_msg, e);
            end
         end
         if (bus1.memreq_val && bus1.memreq_rdy) begin
            if (exp_q1.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_req1: got %h, required no request", bus1.memreq_msg);
            end else begin
               e = exp_q1.pop_front();
               checkw("memreq1", bus1.memreq_msg, e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic [CTRL_W-1:0] ctrl, input logic [31:0] data);
      if (sel) begin
         bus1.net_val = 1'b1; bus1.net_msg_control = ctrl; bus1.net_msg_data = data;
      end else begin
         bus0.net_val = 1'b1; bus0.net_msg_control = ctrl; bus0.net_msg_data = data;
      end
   endtask

   task automatic idle_net();
      bus0.net_val = 1'b0;
      bus1.net_val = 1'b0;
   endtask

   function automatic logic rdy_of(input bit sel);
      return sel ? bus1.net_rdy : bus0.net_rdy;
   endfunction

   // Offer one flit, wait (bounded) for the transfer, then queue the expected request.
   task automatic send(input bit sel, input logic [CTRL_W-1:0] ctrl, input logic [31:0] data,
                       input bit deliver, input logic [REQ_W-1:0] exp);
      bit done;
      int n;
      done = 1'b0;
      n = 0;
      drive(sel, ctrl, data);
      while (!done && n < 20) begin
         if (rdy_of(sel)) done = 1'b1;
         tick();
         n++;
      end
      idle_net();
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: got net_rdy=0 for %0d cycles, required 1", n);
      end else if (deliver) begin
         if (sel) exp_q1.push_back(exp);
         else     exp_q0.push_back(exp);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus0.memreq_rdy = 1'b1;
      bus1.memreq_rdy = 1'b1;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 20) begin
         tick();
         n++;
      end
      check_int("drain_left", exp_q0.size() + exp_q1.size(), 0);
      exp_q0.delete();
      exp_q1.delete();
      tick();
      tick();
   endtask

   // ---------------- test ----------------
   initial begin
      logic [CTRL_W-1:0] c;
      logic [REQ_W-1:0]  r;
      logic [REQ_W-1:0]  ra, rb;
      logic [CTRL_W-1:0] ca, cb;
      logic [7:0]        op;
      logic [31:0]       addr, data;
      logic [2:0]        t;
      logic              acc;

      //              sel dest  dom   type               op     addr           len   data          deliver
      tbl[0] = '{1'b0, 3'd0, 1'b0, memreq_type_read,  8'h25, 32'h0000_0100, 2'd0, 32'h0000_0000, 1'b1};
      tbl[1] = '{1'b0, 3'd0, 1'b1, memreq_type_write, 8'h3C, 32'h0000_1234, 2'd0, 32'h1234_5678, 1'b1};
      tbl[2] = '{1'b0, 3'd1, 1'b0, memreq_type_read,  8'h11, 32'h0000_0040, 2'd0, 32'h0000_0000, 1'b0};
      tbl[3] = '{1'b0, 3'd7, 1'b1, memreq_type_write, 8'h12, 32'h0000_0044, 2'd1, 32'hCAFE_F00D, 1'b0};
      tbl[4] = '{1'b0, 3'd0, 1'b0, memreq_type_write, 8'hE7, 32'hFFFF_FFFC, 2'd3, 32'hA5A5_5A5A, 1'b1};
      tbl[5] = '{1'b1, 3'd2, 1'b0, memreq_type_write, 8'h40, 32'h0000_2000, 2'd0, 32'h1111_2222, 1'b0};
      tbl[6] = '{1'b1, 3'd2, 1'b1, memreq_type_write, 8'h41, 32'h0000_2004, 2'd0, 32'hDEAD_BEEF, 1'b1};
      tbl[7] = '{1'b1, 3'd0, 1'b1, memreq_type_read,  8'h42, 32'h0000_2008, 2'd0, 32'h0000_0000, 1'b0};
      tbl[8] = '{1'b1, 3'd2, 1'b1, memreq_type_read,  8'hFF, 32'h0000_0000, 2'd1, 32'h0000_0000, 1'b1};

      reset = 1'b1;
      bus0.net_val = 1'b0; bus0.net_msg_control = '0; bus0.net_msg_data = '0; bus0.memreq_rdy = 1'b0;
      bus1.net_val = 1'b0; bus1.net_msg_control = '0; bus1.net_msg_data = '0; bus1.memreq_rdy = 1'b0;
      tick(); tick(); tick();
      reset = 1'b0;

      // Reset state
      check1("rst_memreq_val0", bus0.memreq_val, 1'b0);
      check1("rst_net_rdy0",    bus0.net_rdy,    1'b1);
      check1("rst_drop0",       drop0,           1'b0);
      check8("rst_viol0",       viol0,           8'h00);
      check1("rst_net_rdy1",    bus1.net_rdy,    1'b1);

      // Single read: not visible in the accept cycle, valid the cycle after.
      bus0.memreq_rdy = 1'b1;
      c = mk_ctrl(3'd0, 1'b0, memreq_type_read, 8'h25, 32'h100, 2'd0);
      r = mk_req(memreq_type_read, 8'h25, 32'h100, 2'd0, 32'h0);
      drive(1'b0, c, 32'h0);
      check1("t1_val_before", bus0.memreq_val, 1'b0);
      tick();
      idle_net();
      exp_q0.push_back(r);
      check1("t1_val_after", bus0.memreq_val, 1'b1);
      r = bus0.memreq_msg;
      check8("t1_opaque", r[REQ_W-4 -: 8], 8'h25);
      tick();

      // Table of routing / domain vectors on both banks.
      for (int i = 0; i < 9; i++) begin
         c = mk_ctrl(tbl[i].dest, tbl[i].dom, tbl[i].t, tbl[i].op, tbl[i].addr, tbl[i].len);
         r = mk_req(tbl[i].t, tbl[i].op, tbl[i].addr, tbl[i].len, tbl[i].data);
         send(tbl[i].sel, c, tbl[i].data, tbl[i].deliver, r);
         if (!tbl[i].deliver) begin
            if (tbl[i].sel) drops1++;
            else            drops0++;
         end
         if (tbl[i].sel) begin
            check1("vec_drop1", drop1, !tbl[i].deliver);
            check8("vec_viol1", viol1, exp_viol(drops1));
            tick();
            check1("vec_drop1_clear", drop1, 1'b0);
         end else begin
            check1("vec_drop0", drop0, !tbl[i].deliver);
            check8("vec_viol0", viol0, exp_viol(drops0));
            tick();
            check1("vec_drop0_clear", drop0, 1'b0);
         end
      end
      drain();

      // Back-pressure: two fill the queue, the third waits for one dequeue.
      bus0.memreq_rdy = 1'b0;
      ca = mk_ctrl(3'd0, 1'b0, memreq_type_read, 8'hA1, 32'h0000_0A00, 2'd0);
      ra = mk_req(memreq_type_read, 8'hA1, 32'h0000_0A00, 2'd0, 32'h0);
      send(1'b0, ca, 32'h0, 1'b1, ra);
      cb = mk_ctrl(3'd0, 1'b0, memreq_type_write, 8'hB2, 32'h0000_0B00, 2'd0);
      rb = mk_req(memreq_type_write, 8'hB2, 32'h0000_0B00, 2'd0, 32'hBBBB_0002);
      send(1'b0, cb, 32'hBBBB_0002, 1'b1, rb);
      c = mk_ctrl(3'd0, 1'b0, memreq_type_write, 8'hC3, 32'h0000_0C00, 2'd2);
      r = mk_req(memreq_type_write, 8'hC3, 32'h0000_0C00, 2'd2, 32'hCCCC_0003);
      drive(1'b0, c, 32'hCCCC_0003);
      check1("bp_full", bus0.net_rdy, 1'b0);
      tick();
      check1("bp_still_full", bus0.net_rdy, 1'b0);
      bus0.memreq_rdy = 1'b1;
      #1;
      check1("bp_full_deq_same_cycle", bus0.net_rdy, 1'b0);
      tick();
      check1("bp_rdy_after_deq", bus0.net_rdy, 1'b1);
      send(1'b0, c, 32'hCCCC_0003, 1'b1, r);
      drain();

      // Streaming: one request per cycle with both sides always ready.
      bus0.memreq_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         op   = 8'($urandom_range(0, 255));
         addr = $urandom();
         data = $urandom();
         t    = (i % 2 == 1) ? memreq_type_write : memreq_type_read;
         drive(1'b0, mk_ctrl(3'd0, 1'($urandom_range(0, 1)), t, op, addr, 2'd0), data);
         check1("stream_rdy", bus0.net_rdy, 1'b1);
         if (i > 0) check1("stream_val", bus0.memreq_val, 1'b1);
         acc = bus0.net_rdy;
         tick();
         if (acc) exp_q0.push_back(mk_req(t, op, addr, 2'd0, data));
      end
      idle_net();
      drain();

      // Reset with two requests queued: both are discarded.
      bus0.memreq_rdy = 1'b0;
      send(1'b0, ca, 32'h0, 1'b1, ra);
      send(1'b0, cb, 32'hBBBB_0002, 1'b1, rb);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
      drops0 = 0;
      drops1 = 0;
      check1("rst2_memreq_val", bus0.memreq_val, 1'b0);
      check1("rst2_net_rdy",    bus0.net_rdy,    1'b1);
      check8("rst2_viol0",      viol0,           8'h00);
      check8("rst2_viol1",      viol1,           8'h00);
      drain();

      // 300 misrouted flits: counter saturates when enabled.
      for (int i = 0; i < 300; i++) begin
         c = mk_ctrl(3'd1, 1'b1, memreq_type_read, 8'($urandom_range(0, 255)), $urandom(), 2'd0);
         send(1'b0, c, $urandom(), 1'b0, '0);
         drops0++;
      end
      check1("sat_drop", drop0, 1'b1);
      check8("sat_viol", viol0, exp_viol(drops0));
      tick();
      check1("sat_drop_clear", drop0, 1'b0);
      check8("sat_viol_hold", viol0, exp_viol(drops0));
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
